iter_cmp_serial: RTL and testbench



---
 rtl/iter_cmp_pkg.sv | 30 +++
 rtl/iter_cmp_slice.sv | 27 ++
 rtl/iter_cmp_serial.sv | 122 ++++++++++++
 tb/tb_iter_cmp_serial.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/iter_cmp_pkg.sv
// Shared encodings and the result function for the serial iterative comparator.
package iter_cmp_pkg;

    typedef enum logic [1:0] {
        ST_EQ = 2'b00,
        ST_GT = 2'b01,
        ST_LT = 2'b10
    } cell_st_e;

    localparam logic [1:0] MODE_GT = 2'b00;
    localparam logic [1:0] MODE_EQ = 2'b01;
    localparam logic [1:0] MODE_LT = 2'b10;
    localparam logic [1:0] MODE_GE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } fsm_st_e;

    function automatic logic result_f(input logic [1:0] mode, input logic [1:0] x);
        case (mode)
            MODE_GT: return x == ST_GT;
            MODE_EQ: return x == ST_EQ;
            MODE_LT: return x == ST_LT;
            default: return x != ST_LT;
        endcase
    endfunction

endpackage

// File: rtl/iter_cmp_slice.sv
// Combinational cell slice: folds BPC bit pairs into the running comparison state.
module iter_cmp_slice #(
    parameter int unsigned BPC = 1
) (
    input  logic [BPC-1:0] a_sl,
    input  logic [BPC-1:0] b_sl,
    input  logic [1:0]     x_in,
    input  logic           dir,
    output logic [1:0]     x_out
);
    import iter_cmp_pkg::*;

    // dir=0: later (higher) bits overwrite; dir=1: first difference from the MSB sticks.
    always_comb begin
        x_out = x_in;
        if (!dir) begin
            for (int i = 0; i < int'(BPC); i++) begin
                if (a_sl[i] != b_sl[i]) x_out = a_sl[i] ? ST_GT : ST_LT;
            end
        end else begin
            for (int i = int'(BPC) - 1; i >= 0; i--) begin
                if (x_out == ST_EQ && a_sl[i] != b_sl[i]) x_out = a_sl[i] ? ST_GT : ST_LT;
            end
        end
    end

endmodule

// File: rtl/iter_cmp_serial.sv
// Serial comparator stepping BPC bits per clock through one reused cell slice.
// Optional early termination for dir=1 is enabled by defining ITER_CMP_EARLY_TERM_EN.
module iter_cmp_serial #(
    parameter int unsigned N   = 4,
    parameter int unsigned BPC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dir,
    input  logic [1:0] mode,
    input  logic [N:0] a_p,
    input  logic [N:0] b_p,
    output logic [1:0] x_p,
    output logic       busy,
    output logic       done,
    output logic       Z
);
    import iter_cmp_pkg::*;

    localparam int unsigned W     = N + 1;
    localparam int unsigned STEPS = W / BPC;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((W % BPC) != 0) begin : g_bad_bpc
        $error("iter_cmp_serial: BPC must divide N+1");
    end

    fsm_st_e         state_q, state_d;
    logic [N:0]      a_q, b_q;
    logic [1:0]      mode_q;
    logic            dir_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      x_q, x_next;
    logic            z_q, done_q;
    logic [CW-1:0]   sidx;
    logic [BPC-1:0]  a_sl, b_sl;
    logic            last_step, early;

    // dir=1 walks slices from the top, so the slice index counts down.
    always_comb begin
        sidx = dir_q ? (CW'(STEPS - 1) - cnt_q) : cnt_q;
        a_sl = BPC'(a_q >> (sidx * BPC));
        b_sl = BPC'(b_q >> (sidx * BPC));
    end

    iter_cmp_slice #(
        .BPC (BPC)
    ) u_slice (
        .a_sl  (a_sl),
        .b_sl  (b_sl),
        .x_in  (x_q),
        .dir   (dir_q),
        .x_out (x_next)
    );

    assign last_step = (cnt_q == CW'(STEPS - 1));
`ifdef ITER_CMP_EARLY_TERM_EN
    assign early = dir_q && (x_next != ST_EQ);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_step || early) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DONE);
        done = done_q;
        Z    = z_q;
        x_p  = x_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
            dir_q  <= 1'b0;
            cnt_q  <= '0;
            x_q    <= ST_EQ;
            z_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= a_p;
                        b_q    <= b_p;
                        mode_q <= mode;
                        dir_q  <= dir;
                        cnt_q  <= '0;
                        x_q    <= ST_EQ;
                    end
                end
                S_RUN: begin
                    x_q   <= x_next;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    z_q    <= result_f(mode_q, x_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_cmp_serial.sv
// Self-checking bench: integer-level reference model plus directed literal vectors.
module tb_iter_cmp_serial;

    localparam int STEPS = 5;

    logic       clk = 1'b0;
    logic       rst_n, start, start5, dir;
    logic [1:0] mode;
    logic [4:0] a, b;
    logic [1:0] x_p, x5;
    logic       busy, done, z, busy5, done5, z5;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    iter_cmp_serial #(.N(4), .BPC(1)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .dir (dir), .mode (mode),
        .a_p (a), .b_p (b), .x_p (x_p), .busy (busy), .done (done), .Z (z)
    );

    iter_cmp_serial #(.N(4), .BPC(5)) dut5 (
        .clk (clk), .rst_n (rst_n), .start (start5), .dir (dir), .mode (mode),
        .a_p (a), .b_p (b), .x_p (x5), .busy (busy5), .done (done5), .Z (z5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] cmp_x(input logic [4:0] ta, input logic [4:0] tb);
        if (ta > tb) return 2'b01;
        if (ta < tb) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic cmp_z(input logic [4:0] ta, input logic [4:0] tb,
                                   input logic [1:0] tm);
        case (tm)
            2'd0:    return ta > tb;
            2'd1:    return ta == tb;
            2'd2:    return ta < tb;
            default: return ta >= tb;
        endcase
    endfunction

    // Edges from acceptance until the done pulse is visible.
    function automatic int calc_lat(input logic [4:0] ta, input logic [4:0] tb, input logic d);
`ifdef ITER_CMP_EARLY_TERM_EN
        if (d) for (int k = 0; k < STEPS; k++) if (ta[4-k] != tb[4-k]) return k + 2;
`else
        if (d) return STEPS + 1;
`endif
        return STEPS + 1;
    endfunction

    logic       m_busy, m_done, m_z, p_z;
    logic [1:0] m_x, p_x;
    int         m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_z = 1'b0; m_x = 2'b00; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_z = p_z; m_x = p_x;
                end
            end else if (start) begin
                m_busy = 1'b1;
                p_x    = cmp_x(a, b);
                p_z    = cmp_z(a, b, mode);
                m_left = calc_lat(a, b, dir);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
            if (!m_busy) begin
                chk("z_hold", {31'b0, z}, {31'b0, m_z});
                chk("x_hold", {30'b0, x_p}, {30'b0, m_x});
            end
        end
    end

    task automatic run(input bit use5, input logic [4:0] ta, input logic [4:0] tb,
                       input logic [1:0] tm, input logic td, input logic ez,
                       input logic [1:0] ex, input int elat, input string nm);
        int cyc;
        bit seen;
        @(negedge clk);
        a = ta; b = tb; mode = tm; dir = td;
        if (use5) start5 = 1'b1; else start = 1'b1;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            start = 1'b0; start5 = 1'b0;
            cyc++;
            if (use5 ? done5 : done) seen = 1;
        end
        chk({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({nm, "_latency"}, cyc - 1, elat);
        chk({nm, "_z"}, {31'b0, use5 ? z5 : z}, {31'b0, ez});
        chk({nm, "_x"}, {30'b0, use5 ? x5 : x_p}, {30'b0, ex});
        if (use5) chk({nm, "_busy_low"}, {31'b0, busy5}, 32'd0);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, {31'b0, use5 ? done5 : done}, 32'd0);
    endtask

    int lat_early, lat_d1, pulses;
    logic z_at_done;

    initial begin
`ifdef ITER_CMP_EARLY_TERM_EN
        lat_early = 2;
        lat_d1    = 4;
`else
        lat_early = 6;
        lat_d1    = 6;
`endif
        rst_n = 1'b0; start = 1'b0; start5 = 1'b0; dir = 1'b0; mode = 2'b00;
        a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_z", {31'b0, z}, 32'd0);
        chk("rst_x", {30'b0, x_p}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        run(0, 5'd22, 5'd19, 2'b00, 1'b0, 1'b1, 2'b01, 6, "gt_d0");
        run(0, 5'd22, 5'd19, 2'b10, 1'b0, 1'b0, 2'b01, 6, "lt_d0");
        run(0, 5'd22, 5'd19, 2'b11, 1'b1, 1'b1, 2'b01, lat_d1, "ge_d1");
        for (int d = 0; d < 2; d++) begin
            run(0, 5'd13, 5'd13, 2'b01, d[0], 1'b1, 2'b00, 6, "eq_m01");
            run(0, 5'd13, 5'd13, 2'b11, d[0], 1'b1, 2'b00, 6, "eq_m11");
            run(0, 5'd13, 5'd13, 2'b00, d[0], 1'b0, 2'b00, 6, "eq_m00");
        end
        run(0, 5'd16, 5'd15, 2'b00, 1'b1, 1'b1, 2'b01, lat_early, "early");
        run(1, 5'd3, 5'd9, 2'b10, 1'b0, 1'b1, 2'b10, 2, "bpc5");

        // Operands and start changed mid-RUN must not disturb the captured compare.
        @(negedge clk);
        a = 5'd5; b = 5'd9; mode = 2'b10; dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 5'd31; b = 5'd0; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        z_at_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                z_at_done = z;
            end
        end
        chk("restart_pulses", pulses, 1);
        chk("restart_z", {31'b0, z_at_done}, 32'd1);
        chk("restart_x", {30'b0, x_p}, 32'd2);

        // Asynchronous reset during RUN step 3.
        @(negedge clk);
        a = 5'd22; b = 5'd19; mode = 2'b00; dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_x", {30'b0, x_p}, 32'd0);
        chk("arst_z", {31'b0, z}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("arst_no_done", pulses, 0);
        run(0, 5'd22, 5'd19, 2'b00, 1'b0, 1'b1, 2'b01, 6, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
